// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Parametrised register file with two combinational read ports,
//            one synchronous write port, optional write-to-read bypass,
//            optional hardwired-zero register 0, a per-register pending
//            scoreboard and a sequenced multi-cycle clear sweep.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1          rising-edge clock
//   reset_n      in   1          asynchronous active-low reset
//   addr1/addr2  in   ADDR_BITS  read port addresses
//   data1/data2  out  WORD_SIZE  read port data (combinational)
//   write        in   1          write enable
//   addr3        in   ADDR_BITS  write address
//   data3        in   WORD_SIZE  write data
//   reserve      in   1          mark reserve_addr pending
//   reserve_addr in   ADDR_BITS  register to reserve
//   pend1/pend2  out  1          pending status of addr1/addr2
//   clear_req    in   1          start clear sweep of all registers
//   clear_busy   out  1          high while the clear sweep runs
// ============================================================================
module regfile_sb #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [ADDR_BITS-1:0] addr2,
  output logic [WORD_SIZE-1:0] data1,
  output logic [WORD_SIZE-1:0] data2,
  input  logic                 write,
  input  logic [ADDR_BITS-1:0] addr3,
  input  logic [WORD_SIZE-1:0] data3,
  input  logic                 reserve,
  input  logic [ADDR_BITS-1:0] reserve_addr,
  output logic                 pend1,
  output logic                 pend2,
  input  logic                 clear_req,
  output logic                 clear_busy
);

  localparam int NREG = 2**ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_REG = ADDR_BITS'(NREG - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]      pend_q, pend_d;
  logic [WORD_SIZE-1:0] mem_q [NREG];

  logic                 wr_en;

  // Writes to register 0 are dropped when it is hardwired to zero.
  assign wr_en = (state_q == S_IDLE) && write &&
                 !((ZERO_REG != 0) && (addr3 == '0));

  // Control FSM and sweep counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_REG) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scoreboard update; reserve is applied after write so it wins on a tie.
  always_comb begin
    pend_d = pend_q;
    if (state_q == S_IDLE) begin
      if (write)   pend_d[addr3]        = 1'b0;
      if (reserve) pend_d[reserve_addr] = 1'b1;
    end else begin
      pend_d[cnt_q] = 1'b0;
    end
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      if (state_q == S_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_en) begin
        mem_q[addr3] <= data3;
      end
    end
  end

  assign clear_busy = (state_q == S_CLEAR);

  // Read ports: zero register overrides bypass, bypass overrides storage.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [ADDR_BITS-1:0] raddr;
    logic                 fwd;
    logic                 zero;
    logic [WORD_SIZE-1:0] rdata;
    logic                 rpend;

    assign raddr = (p == 0) ? addr1 : addr2;
    assign fwd   = (BYPASS != 0) && (state_q == S_IDLE) && write && (addr3 == raddr);
    assign zero  = (ZERO_REG != 0) && (raddr == '0);
    assign rdata = zero ? '0   : (fwd ? data3 : mem_q[raddr]);
    assign rpend = zero ? 1'b0 : (fwd ? 1'b0  : pend_q[raddr]);
  end

  assign data1 = g_rd[0].rdata;
  assign data2 = g_rd[1].rdata;
  assign pend1 = g_rd[0].rpend;
  assign pend2 = g_rd[1].rpend;

endmodule
`default_nettype wire
